// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the burst memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} burst_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_rd_stage.sv
// One-entry read output register: loads on load_i, drops valid once the consumer takes it.
module mem_rd_stage
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // A load always wins over a pop: the caller only loads when the slot is free or being taken.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for a single-port async-read memory: write/read bursts over valid/ready ports.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  burst_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  rd_load;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_din   = '0;
    rd_load   = 1'b0;
    // Handshake outputs are masked during reset so nothing is accepted or written that cycle.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            ptr_d = cmd_addr;
            cnt_d = cmd_len;
            if (cmd_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = (cmd_op == OP_WRITE) ? WR : RD;
            end
          end
        end
        WR: begin
          wr_ready = 1'b1;
          mem_din  = wr_data;
          if (wr_valid) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        RD: begin
          rd_load = !rd_valid || rd_ready;
          if (rd_load) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              state_d = RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (rd_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  mem_rd_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_stage (
    .clk     (clk),
    .rst     (rst),
    .load_i  (rd_load),
    .data_i  (mem_dout),
    .ready_i (rd_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data)
  );

  assign mem_addr = ptr_q;
  assign done     = done_q;

endmodule
